universal_shift_register_param: RTL
===================================

Name: universal_shift_register_param

Overview:
- Parametrised successor to the team's 4-bit universal shift register.
- WIDTH-bit register with eight per-cycle modes: hold, logical/arithmetic shift, rotate and parallel load.
- Adds a clock-enable, serial-out taps, and a multi-cycle burst shift (N single-bit steps, busy/done handshake).
- Used as the shared serialiser/deserialiser and barrel-less shifter in datapath blocks.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 64.
- CNT_W, $clog2(WIDTH)+1, width of the burst shift count; derived, do not override.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- en  in  1  per-cycle operation enable; ignored in BURST
- mode  in  3  operation select (encoding in Behaviour)
- data_in  in  WIDTH  parallel load value
- serial_in_l  in  1  bit shifted into q[0] on left shifts
- serial_in_r  in  1  bit shifted into q[WIDTH-1] on right logical shifts
- start  in  1  burst request; sampled only in IDLE
- shift_cnt  in  CNT_W  burst step count, captured at start
- q  out  WIDTH  register contents
- serial_out_l  out  1  equals q[WIDTH-1], combinational from q
- serial_out_r  out  1  equals q[0], combinational from q
- busy  out  1  high while in BURST
- done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (reset==0, asynchronous):
  - q=0, busy=0, done=0, FSM=IDLE, internal count=0, captured mode=0.
  - Reset release is synchronous to clock.
- Mode encoding, applied at the clock edge when in IDLE, en=1, start=0:
  - 000 hold
  - 001 shift left: {q[W-2:0], serial_in_l}
  - 010 shift right logical: {serial_in_r, q[W-1:1]}
  - 011 shift right arithmetic: {q[W-1], q[W-1:1]}
  - 100 rotate left: {q[W-2:0], q[W-1]}
  - 101 rotate right: {q[0], q[W-1:1]}
  - 110 parallel load: q <= data_in
  - 111 reserved, behaves as hold
- en=0 in IDLE with start=0: q holds.
- FSM states: IDLE and BURST.
- IDLE to BURST:
  - Occurs on start=1 with mode in 001..101 and shift_cnt != 0; en is ignored.
  - Captures mode and shift_cnt; q is unchanged on this edge.
  - busy rises on the next cycle.
- start=1 with shift_cnt==0 or mode not in 001..101:
  - No state change, q unchanged.
  - done pulses high on the next cycle (degenerate burst).
- BURST:
  - Each cycle: one step of the captured mode, count decrements.
  - Serial inputs are sampled live each step.
  - mode, en, start and data_in are ignored.
- Exit: after the edge that performs the final step (count 1 to 0), FSM returns to IDLE.
  - busy=0 and done=1 are visible in the same cycle that q shows the final result.
- done timing:
  - Burst of N steps: done high exactly N+1 cycles after the start edge.
  - done stays high for exactly one cycle.
- start in the done cycle is accepted as a new burst; back-to-back bursts are allowed.
- shift_cnt greater than WIDTH is legal: rotates wrap; shifts saturate naturally (all fill bits).
- Reset asserted mid-burst: immediate abort to the reset values; no done pulse.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined:
  - Adds output port q_parity (1 bit), a registered even parity (XOR reduction) of the next value of q.
  - Updated on every edge q updates, so q_parity always equals ^q.
  - Reset value 0.
- Undefined: port absent; no parity logic.

Test Plan:
- Reset and load:
  - WIDTH=8; reset=0 mid-cycle -> q=0x00, busy=0 asynchronously.
  - Release reset, en=1, mode=110, data_in=0xA5 -> q=0xA5 after one edge.
- Shift/rotate:
  - q=0xA5, mode=001, serial_in_l=1 -> q=0x4B.
  - mode=011 from q=0x96 -> 0xCB.
  - mode=101 from q=0x01 -> 0x80.
  - serial_out_r tracks q[0].
- Enable and reserved mode:
  - q=0x3C, en=0 with mode=001 for 5 cycles -> q stays 0x3C.
  - mode=111, en=1 -> q stays 0x3C.
- Burst:
  - q=0x81, start=1, mode=100, shift_cnt=3 -> busy high for 3 cycles.
  - done pulses once 4 cycles after start; q=0x0C.
  - mode/data_in toggling during busy has no effect.
- Degenerate and back-to-back:
  - start with shift_cnt=0 -> done next cycle, busy never high, q unchanged.
  - start asserted in the done cycle -> second burst begins, no idle gap.
- Reset mid-burst:
  - shift_cnt=6, reset=0 after 2 steps -> q=0, busy=0, no done.
  - With USR_PARITY_EN: q_parity=0 after reset, and =1 after loading 0x07.

Source files
------------

// File: rtl/universal_shift_register_param.sv
// universal_shift_register_param
//   WIDTH-bit universal shift register: hold, logical/arithmetic shift, rotate
//   and parallel load per cycle, plus a multi-step burst shift with a
//   busy/done handshake.
//   Optional feature macro: USR_PARITY_EN adds q_parity, a registered even
//   parity of q (always equal to ^q).
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   en           per-cycle enable (ignored during a burst)
//   mode[2:0]    operation select
//   data_in      parallel load value
//   serial_in_l  fill bit for left shifts (into q[0])
//   serial_in_r  fill bit for logical right shifts (into q[WIDTH-1])
//   start        burst request, sampled only in IDLE
//   shift_cnt    burst step count, captured at start
//   q            register contents
//   serial_out_l q[WIDTH-1]
//   serial_out_r q[0]
//   busy         high while a burst is in progress
//   done         one-cycle pulse when a burst (or degenerate burst) completes
module universal_shift_register_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_l,
  output logic             serial_out_r,
  output logic             busy,
`ifdef USR_PARITY_EN
  output logic             q_parity,
`endif
  output logic             done
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       cap_mode, cap_mode_n;
  logic             done_n;
  logic             burst_ok;

  // One step of the given mode applied to v.
  function automatic logic [WIDTH-1:0] step(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    case (m)
      3'b001:  r = {v[WIDTH-2:0], sl};
      3'b010:  r = {sr, v[WIDTH-1:1]};
      3'b011:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      3'b100:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      3'b101:  r = {v[0], v[WIDTH-1:1]};
      3'b110:  r = ld;
      default: r = v;
    endcase
    return r;
  endfunction

  // Only shift/rotate modes with a non-zero count start a real burst;
  // anything else collapses to an immediate done pulse.
  assign burst_ok = (mode >= 3'b001) && (mode <= 3'b101) && (shift_cnt != '0);

  always_comb begin
    state_n    = state;
    q_n        = q;
    cnt_n      = cnt;
    cap_mode_n = cap_mode;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (burst_ok) begin
            state_n    = BURST;
            cnt_n      = shift_cnt;
            cap_mode_n = mode;
          end else begin
            done_n = 1'b1;
          end
        end else if (en) begin
          q_n = step(mode, q, data_in, serial_in_l, serial_in_r);
        end
      end
      BURST: begin
        q_n   = step(cap_mode, q, data_in, serial_in_l, serial_in_r);
        cnt_n = cnt - 1'b1;
        // Final step: leave BURST so busy drops as done rises with the result.
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      q        <= '0;
      cnt      <= '0;
      cap_mode <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      cnt      <= cnt_n;
      cap_mode <= cap_mode_n;
      done     <= done_n;
    end
  end

`ifdef USR_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q_parity <= 1'b0;
    else        q_parity <= ^q_n;
  end
`endif

  assign busy         = (state == BURST);
  assign serial_out_l = q[WIDTH-1];
  assign serial_out_r = q[0];

endmodule
